mips32_mem_responder: RTL
=========================

# mips32_mem_responder

Single-port, word-addressed data-memory responder serving the load/store side of the pipelined MIPS32 core. It accepts one request at a time over a valid/ready request channel, performs a write or read on a 1024×32 array, and returns exactly one in-order response per request over a valid/ready response channel after a programmable latency. It replaces the core's direct array access with a handshaked slave, so memory wait states can be modelled.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two.
- `AW`, 10: index width; log2(`DEPTH`).
- `LATENCY`, 2: cycles from request acceptance to `rsp_valid`; legal range 1..7.
- `clk1`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_we`  in  1  1 = store (SW), 0 = load (LW).
- `req_addr`  in  32  word address, as produced by the core's ALU.
- `req_wdata`  in  32  store data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  initiator consumes response.
- `rsp_data`  out  32  load data; 0 for stores and errors.
- `rsp_we`  out  1  echo of `req_we` for this response.
- `rsp_err`  out  1  address out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- `req_ready` = (state == IDLE) && !rst. Accept = `req_valid && req_ready` at a posedge.
- On accept:
  - Latch `req_we` into `rsp_we`.
  - Range check: err = (`req_addr[31:AW]` != 0).
  - Store, in range: write `mem[req_addr[AW-1:0]] <= req_wdata` at the accept edge. Latch `rsp_data` = 0.
  - Load, in range: latch `rsp_data` = `mem[index]`, the pre-write contents at that edge.
  - Error: no array write. Latch `rsp_data` = 0 and `rsp_err` = 1.
  - Load counter `lat_cnt` = `LATENCY`-1.
  - Next state: RESP if `LATENCY` == 1, else WAIT.
- WAIT: decrement `lat_cnt` each cycle. Move to RESP on the edge where `lat_cnt` == 1.
- RESP: `rsp_valid` = 1. When `rsp_ready` is sampled 1, go to IDLE and clear `rsp_valid`. No new request is accepted on that same edge.
- `rsp_data`, `rsp_we` and `rsp_err` hold stable while `rsp_valid && !rsp_ready`.
- `req_*` inputs are sampled only on the accept edge. Changes while `req_ready` = 0 are ignored. The initiator holds the request stable until accepted.
- Ordering: strictly one outstanding request. Responses come in request order.
- Memory contents are not reset. The bench preloads via hierarchical `mem[]`.

## Timing
- Reset (async assert, any state): state = IDLE, `rsp_valid` = 0, `rsp_data` = 0, `rsp_we` = 0, `rsp_err` = 0, `lat_cnt` = 0, `req_ready` = 0 while `rst` is high.
  - A request in flight is dropped with no response.
  - A store whose accept edge already occurred remains written.
- First accept is possible on the first posedge after `rst` deasserts.
- Accept at edge N → `rsp_valid` high after edge N+`LATENCY`.
- With `rsp_ready` tied high: response consumed at edge N+`LATENCY`+1, `req_ready` high after that edge, next accept at N+`LATENCY`+2.
- Peak throughput: one request per `LATENCY`+2 cycles.
- Backpressure: each cycle `rsp_ready` is low adds one cycle.
- `rsp_ready` high while `rsp_valid` is low: ignored.
- `req_valid` high in WAIT/RESP: no effect; the request waits for IDLE.
- Address wrap: no wrap. Any nonzero bit above `AW`-1 is an error. Index `DEPTH`-1 is valid.

## Test plan
- Store then load, `LATENCY`=2, `rsp_ready`=1: SW `addr`=121 `wdata`=130, then LW `addr`=121 → store response `rsp_we`=1 `rsp_data`=0; load `rsp_data`=130 `rsp_err`=0; `rsp_valid` exactly 2 cycles after each accept.
- Latency sweep, `LATENCY`=1 and 7: preload `mem[200]`=7, LW `addr`=200 → `rsp_data`=7 with `rsp_valid` 1 / 7 cycles after accept; `req_ready` low from accept until the cycle after consume.
- Backpressure: LW `addr`=120 (preload 85), hold `rsp_ready`=0 for 5 cycles while toggling `req_addr`/`req_valid` → `rsp_data` stays 85, `rsp_valid` stays 1, no second accept; consumed on the first `rsp_ready`=1 edge.
- Out of range: SW `addr`=1024 `wdata`=0xDEAD, then LW `addr`=0 → first response `rsp_err`=1 `rsp_data`=0; `mem[0]` unchanged.
- Boundary: SW `addr`=1023 `wdata`=0xFFFFFFFF, then LW `addr`=1023 → `rsp_data`=0xFFFFFFFF, `rsp_err`=0.
- Reset mid-operation: accept LW `addr`=5, assert `rst` during WAIT → `rsp_valid` never rises, all outputs 0; after release, LW `addr`=5 completes normally with the preloaded value.

Source files
------------

// File: rtl/mips32_mem_responder.sv
// rtl/mips32_mem_responder.sv - handshaked 1024x32 data-memory responder with programmable latency
module mips32_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_we,
    output logic        rsp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [2:0]    lat_cnt;
    logic [31:0]   mem [0:DEPTH-1];
    logic          accept;
    logic          addr_err;
    logic [AW-1:0] idx;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[AW-1:0];
    assign addr_err  = |req_addr[31:AW];

    // Array is never reset so contents survive a mid-operation reset.
    always_ff @(posedge clk1) begin
        if (accept && req_we && !addr_err) begin
            mem[idx] <= req_wdata;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_we    <= 1'b0;
            rsp_err   <= 1'b0;
            lat_cnt   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_we   <= req_we;
                        rsp_err  <= addr_err;
                        rsp_data <= (req_we || addr_err) ? 32'd0 : mem[idx];
                        lat_cnt  <= 3'(LATENCY - 1);
                        state    <= WAIT;
                    end
                end
                // Counter hits zero LATENCY-1 edges after accept; the next edge raises rsp_valid.
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
